cpu_prog_sequencer: RTL
=======================

Name: cpu_prog_sequencer

Overview:
Program sequencer for cpu_top. It holds a small program memory of 11-bit instructions ({opcode[2:0], dest[3:0], src/val[3:0]}) and issues them one at a time to the CPU. Each instruction is held stable for the CPU's 3-cycle FETCH→EXEC→STORE window, and the sequencer controls the CPU's reset so the two phase counters stay aligned. It supports run-to-end, single-step and abort, and replaces hand-driven instruction stimulus at system level.

Parameters:
ADDR_W, 4, program address width; memory depth = 2**ADDR_W
INSTR_W, 11, instruction width (must match cpu_top)

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
prog_we  input  1  program memory write strobe
prog_addr  input  ADDR_W  program write address
prog_data  input  INSTR_W  program write data
end_addr  input  ADDR_W  address of last instruction; sampled on accepted start
start  input  1  begin run at address 0 (single-cycle pulse)
step_mode  input  1  1 = pause after every retired instruction
step  input  1  release one instruction while paused (pulse)
abort  input  1  terminate run immediately
instruction  output  INSTR_W  to cpu_top.instruction
cpu_reset_n  output  1  to cpu_top.reset_n; low = CPU held in FETCH
instr_valid  output  1  instruction is being executed
pc  output  ADDR_W  address of current or next instruction
phase  output  2  0 = idle/pause/done, 1 = FETCH, 2 = EXEC, 3 = STORE
busy  output  1  run in progress (includes PAUSE)
done  output  1  sticky run-complete flag
retired_count  output  ADDR_W+1  instructions retired in the current run

Behaviour:
- Reset values:
  - State is IDLE.
  - instruction=0, cpu_reset_n=0, instr_valid=0, pc=0, phase=0, busy=0, done=0, retired_count=0.
  - Program memory contents are not cleared.
- States: IDLE, FETCH, EXEC, STORE, PAUSE, DONE. Each of FETCH, EXEC and STORE lasts exactly one cycle.
- Program writes:
  - Memory is written on prog_we only in IDLE or DONE.
  - prog_we is ignored in every other state.
- Start:
  - Accepted only in IDLE or DONE.
  - On the accepting edge: latch end_addr, set pc=0, retired_count=0, done=0.
  - Next state is FETCH with instruction=mem[0], cpu_reset_n=1, instr_valid=1, busy=1.
  - start is ignored in all other states.
- Transitions:
  - FETCH→EXEC→STORE unconditionally.
  - instruction is constant from FETCH through STORE.
- On leaving STORE:
  - retired_count increments.
  - If pc == latched end_addr: go to DONE. Set done=1, busy=0, instr_valid=0, cpu_reset_n=0, pc wraps to pc+1 (mod 2**ADDR_W), instruction holds its last value.
  - Else if step_mode=1: pc=pc+1, go to PAUSE. Set cpu_reset_n=0, instr_valid=0, busy stays 1.
  - Else: pc=pc+1, go to FETCH with instruction=mem[pc+1]. cpu_reset_n stays 1.
- PAUSE:
  - Waits for step, then goes to FETCH with instruction=mem[pc] and cpu_reset_n=1.
  - step in any other state is ignored.
  - Clearing step_mode while in PAUSE does not release the pause; a step pulse is still required.
- CPU contract: holding cpu_reset_n low restarts cpu_top's phase counter at FETCH and does not alter CPU RAM. cpu_reset_n rises on the same edge that loads the instruction, so CPU FETCH coincides with sequencer FETCH.
- Abort:
  - From FETCH, EXEC, STORE or PAUSE: next state is IDLE. Set cpu_reset_n=0, instr_valid=0, busy=0, done=0, instruction=0.
  - pc and retired_count hold their values.
  - An instruction aborted before its STORE cycle completes is not counted.
- Priority: reset > abort > start > step. abort and start in the same cycle leaves the block in IDLE.
- Run length:
  - end_addr=2**ADDR_W−1 runs the full memory: retired_count reaches 16 and pc wraps to 0.
  - The latched end_addr does not change mid-run.
- Throughput without step_mode: one instruction per 3 cycles, with no bubble between instructions.
- Reset mid-run: all outputs return to their reset values on the next edge.

Test Plan:
1. Load STO 4,5 / ADD 4,6 / STO 1,F / SUB 1,7 / NOT F at addresses 0–4, end_addr=4, pulse start → busy for 15 cycles, instruction changes every 3 cycles, then done=1, retired_count=5, pc=5. CPU RAM ends with [4]=B, [1]=8, [F]=F.
2. Same program with step_mode=1 → after each STORE the block enters PAUSE with cpu_reset_n=0 and pc advanced. No progress occurs until a step pulse arrives, and each step retires exactly one instruction; final results match scenario 1.
3. Pulse abort during EXEC of instruction 1 → next cycle IDLE, cpu_reset_n=0, busy=0, done=0, retired_count=1. RAM[4]=5; the ADD is not written.
4. end_addr=F with 16 STO instructions, start → retired_count=16, pc=0, done=1 after 48 busy cycles.
5. While busy: prog_we to address 2, and a start pulse → memory unchanged and the run is unaffected. Start from DONE → clean rerun with done cleared. Start and abort in the same cycle from IDLE → block remains in IDLE.
6. Assert reset during STORE → next edge shows all outputs at reset values; program memory is preserved and a new start executes correctly.

Source files
------------

// File: rtl/cpu_prog_sequencer.sv
// cpu_prog_sequencer: program memory and issue sequencer driving cpu_top one instruction per 3-cycle window
module cpu_prog_sequencer #(
  parameter int ADDR_W = 4,
  parameter int INSTR_W = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [ADDR_W-1:0]  end_addr,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  input  logic               abort,
  output logic [INSTR_W-1:0] instruction,
  output logic               cpu_reset_n,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [1:0]         phase,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W:0]    retired_count
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, STORE, PAUSE, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, end_q, end_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic idle_like, running;
  logic [ADDR_W-1:0] pc_n;
  assign idle_like = state_q == IDLE || state_q == DONE;
  assign running = state_q == FETCH || state_q == EXEC || state_q == STORE;
  assign pc_n = pc_q + 1'b1;
  assign instruction = instr_q;
  assign cpu_reset_n = running;
  assign instr_valid = running;
  assign busy = running || state_q == PAUSE;
  assign done = state_q == DONE;
  assign pc = pc_q;
  assign retired_count = cnt_q;
  assign phase = state_q == FETCH ? 2'd1 : state_q == EXEC ? 2'd2 : state_q == STORE ? 2'd3 : 2'd0;
  // program memory accepts writes only while no run is in progress
  always_ff @(posedge clk)
    if (prog_we && idle_like) mem[prog_addr] <= prog_data;
  // next-state: abort beats start, start beats step; abort while idle just blocks start
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    end_d = end_q;
    cnt_d = cnt_q;
    instr_d = instr_q;
    if (abort) begin
      if (!idle_like) begin
        state_d = IDLE;
        instr_d = '0;
      end
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_d = FETCH;
          pc_d = '0;
          cnt_d = '0;
          end_d = end_addr;
          instr_d = mem[0];
        end
        FETCH: state_d = EXEC;
        EXEC: state_d = STORE;
        STORE: begin
          cnt_d = cnt_q + 1'b1;
          pc_d = pc_n;
          if (pc_q == end_q) state_d = DONE;
          else if (step_mode) state_d = PAUSE;
          else begin
            state_d = FETCH;
            instr_d = mem[pc_n];
          end
        end
        PAUSE: if (step) begin
          state_d = FETCH;
          instr_d = mem[pc_q];
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= '0;
      end_q <= '0;
      cnt_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      end_q <= end_d;
      cnt_q <= cnt_d;
      instr_q <= instr_d;
    end
  end
endmodule
